// File: rtl/fetch_unit_pkg.sv
// Shared state encodings and opcodes for the OSECPU fetch/sequencing logic.
// The datapath decodes current_state against these values, so keep them stable.
package fetch_unit_pkg;

   typedef enum logic [3:0] {
      STATE_HLT      = 4'd0,
      STATE_FETCH0   = 4'd1,
      STATE_FETCH0_L = 4'd2,
      STATE_FETCH1   = 4'd3,
      STATE_FETCH1_L = 4'd4,
      STATE_EXEC     = 4'd5
   } state_e;

   localparam logic [7:0] OP_LIMM32 = 8'h02;
   localparam logic [7:0] OP_PLIMM  = 8'h03;
   localparam logic [7:0] OP_END    = 8'hFF;

endpackage

// File: rtl/fetch_unit_instr_len_decode.sv
// Opcode length classifier: flags two-word instructions and the program terminator.
// New multi-word opcodes are added to o_is_two_word here and nowhere else.
module instr_len_decode
   import fetch_unit_pkg::*;
(
   input  logic [7:0] i_opcode,
   output logic       o_is_two_word,
   output logic       o_is_end
);

   assign o_is_two_word = (i_opcode == OP_LIMM32) || (i_opcode == OP_PLIMM);
   assign o_is_end      = (i_opcode == OP_END);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks pc through a 1-cycle-latency ROM, assembles
// one- or two-word instructions and presents each for exactly one EXEC cycle.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                   PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   output logic [PC_WIDTH-1:0] mem_addr,
   input  logic [31:0]         mem_data,
   input  logic                pc_we,
   input  logic [PC_WIDTH-1:0] pc_din,
   output logic [3:0]          current_state,
   output logic [31:0]         instr0,
   output logic [31:0]         instr1,
   output logic [PC_WIDTH-1:0] pc,
   output logic                halted
);

   state_e              r_state;
   state_e              w_next_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [31:0]         r_instr0;
   logic [31:0]         r_instr1;
   logic                w_is_two_word;
   logic                w_is_end;

   instr_len_decode u_len_decode (
      .i_opcode      (mem_data[31:24]),
      .o_is_two_word (w_is_two_word),
      .o_is_end      (w_is_end)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= STATE_HLT;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         STATE_HLT:      if (run) w_next_state = STATE_FETCH0;
         STATE_FETCH0:   w_next_state = STATE_FETCH0_L;
         STATE_FETCH0_L: begin
            if (w_is_end)           w_next_state = STATE_HLT;
            else if (w_is_two_word) w_next_state = STATE_FETCH1;
            else                    w_next_state = STATE_EXEC;
         end
         STATE_FETCH1:   w_next_state = STATE_FETCH1_L;
         STATE_FETCH1_L: w_next_state = STATE_EXEC;
         STATE_EXEC:     w_next_state = STATE_FETCH0;
         default:        w_next_state = STATE_HLT;
      endcase
   end

   // mem_data is only meaningful in the *_L states, one cycle after the address was presented
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc     <= RESET_PC;
         r_instr0 <= '0;
         r_instr1 <= '0;
      end else begin
         case (r_state)
            STATE_FETCH0_L: begin
               r_instr0 <= mem_data;
               r_pc     <= r_pc + PC_WIDTH'(1);
               if (!w_is_end && !w_is_two_word) r_instr1 <= '0;
            end
            STATE_FETCH1_L: begin
               r_instr1 <= mem_data;
               r_pc     <= r_pc + PC_WIDTH'(1);
            end
            STATE_EXEC: if (pc_we) r_pc <= pc_din;
            default: ;
         endcase
      end
   end

   assign mem_addr      = r_pc;
   assign pc            = r_pc;
   assign instr0        = r_instr0;
   assign instr1        = r_instr1;
   assign current_state = r_state;
   assign halted        = (r_state == STATE_HLT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized program
// run checked against an instruction-level model of the fetch sequence.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          reset, run, pc_we;
   logic [PW-1:0] pc_din, mem_addr, pc;
   logic [31:0]   mem_data, instr0, instr1;
   logic [3:0]    current_state;
   logic          halted;

   logic [31:0]   rom [0:65535];
   int            checks   = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   always @(posedge clk) mem_data <= rom[mem_addr];

   fetch_unit #(.PC_WIDTH(PW), .RESET_PC(16'h0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .pc_we         (pc_we),
      .pc_din        (pc_din),
      .current_state (current_state),
      .instr0        (instr0),
      .instr1        (instr1),
      .pc            (pc),
      .halted        (halted)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; pc_we = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b1; pc_we = 1'b1; pc_din = 16'h1234;
      step();
      step();
      checks++; if (current_state !== 4'(STATE_HLT)) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", current_state, STATE_HLT); end
      checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
      checks++; if (instr0 !== 32'h0) begin failures++; $display("FAIL reset_instr0 got=%h exp=0", instr0); end
      checks++; if (instr1 !== 32'h0) begin failures++; $display("FAIL reset_instr1 got=%h exp=0", instr1); end
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL reset_halted got=%b exp=1", halted); end
      checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
      reset = 1'b0; run = 1'b0; pc_we = 1'b0;
      step();
      checks++; if (current_state !== 4'(STATE_HLT)) begin failures++; $display("FAIL idle_without_run got=%0d exp=%0d", current_state, STATE_HLT); end
   endtask

   task automatic test_one_word();
      do_reset();
      rom[0] = 32'h10041080;
      rom[1] = 32'hFF000000;
      run = 1'b1;
      step();
      run = 1'b0;
      checks++; if (current_state !== 4'(STATE_FETCH0)) begin failures++; $display("FAIL ow_cycle1 got=%0d exp=%0d", current_state, STATE_FETCH0); end
      step();
      checks++; if (current_state !== 4'(STATE_FETCH0_L)) begin failures++; $display("FAIL ow_cycle2 got=%0d exp=%0d", current_state, STATE_FETCH0_L); end
      step();
      checks++; if (current_state !== 4'(STATE_EXEC)) begin failures++; $display("FAIL ow_exec_cycle3 got=%0d exp=%0d", current_state, STATE_EXEC); end
      checks++; if (instr0 !== 32'h10041080) begin failures++; $display("FAIL ow_instr0 got=%h exp=10041080", instr0); end
      checks++; if (instr1 !== 32'h0) begin failures++; $display("FAIL ow_instr1 got=%h exp=0", instr1); end
      checks++; if (pc !== 16'h0001 || halted !== 1'b0) begin failures++; $display("FAIL ow_exec_pc got pc=%h halted=%b exp pc=0001 halted=0", pc, halted); end
      step();
      step();
      step();
      checks++; if (current_state !== 4'(STATE_HLT) || halted !== 1'b1) begin failures++; $display("FAIL ow_end_halt got=%0d/%b exp=%0d/1", current_state, halted, STATE_HLT); end
      checks++; if (pc !== 16'h0002) begin failures++; $display("FAIL ow_end_pc got=%h exp=0002", pc); end
   endtask

   task automatic test_two_word();
      int n;
      do_reset();
      rom[0] = 32'h02040000;
      rom[1] = 32'hDEADBEEF;
      rom[2] = 32'hFF000000;
      run = 1'b1;
      step();
      run = 1'b0;
      n = 1;
      while (current_state !== 4'(STATE_EXEC) && n < 12) begin step(); n++; end
      checks++; if (n != 5 || current_state !== 4'(STATE_EXEC)) begin failures++; $display("FAIL tw_latency got=%0d exp=5", n); end
      checks++; if (instr0 !== 32'h02040000) begin failures++; $display("FAIL tw_instr0 got=%h exp=02040000", instr0); end
      checks++; if (instr1 !== 32'hDEADBEEF) begin failures++; $display("FAIL tw_instr1 got=%h exp=deadbeef", instr1); end
      checks++; if (pc !== 16'h0002) begin failures++; $display("FAIL tw_exec_pc got=%h exp=0002", pc); end
      n = 0;
      while (current_state !== 4'(STATE_HLT) && n < 12) begin step(); n++; end
      checks++; if (n != 3 || pc !== 16'h0003) begin failures++; $display("FAIL tw_end got cycles=%0d pc=%h exp cycles=3 pc=0003", n, pc); end
   endtask

   task automatic test_jump();
      do_reset();
      rom[0]     = 32'h10000000;
      rom[16'h40] = 32'hFF000000;
      run = 1'b1;
      step();
      run = 1'b0;
      pc_we = 1'b1; pc_din = 16'h0020;
      step();
      checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL jump_ignored_fetch0 got=%h exp=0000", pc); end
      step();
      checks++; if (current_state !== 4'(STATE_EXEC) || pc !== 16'h0001) begin failures++; $display("FAIL jump_ignored_fetch0l got state=%0d pc=%h exp state=%0d pc=0001", current_state, pc, STATE_EXEC); end
      pc_din = 16'h0040;
      step();
      pc_we = 1'b0;
      checks++; if (current_state !== 4'(STATE_FETCH0) || mem_addr !== 16'h0040) begin failures++; $display("FAIL jump_target got state=%0d addr=%h exp state=%0d addr=0040", current_state, mem_addr, STATE_FETCH0); end
      step();
      step();
      checks++; if (current_state !== 4'(STATE_HLT) || pc !== 16'h0041) begin failures++; $display("FAIL jump_end got state=%0d pc=%h exp state=%0d pc=0041", current_state, pc, STATE_HLT); end
   endtask

   task automatic test_wrap();
      do_reset();
      rom[0]        = 32'h10000000;
      rom[16'hFFFF] = 32'h20000000;
      rom[16'h80]   = 32'hFF000000;
      run = 1'b1;
      step();
      run = 1'b0;
      step();
      step();
      pc_we = 1'b1; pc_din = 16'hFFFF;
      step();
      pc_we = 1'b0;
      checks++; if (mem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_addr got=%h exp=ffff", mem_addr); end
      step();
      step();
      checks++; if (current_state !== 4'(STATE_EXEC) || pc !== 16'h0000 || instr0 !== 32'h20000000) begin failures++; $display("FAIL wrap_pc got state=%0d pc=%h instr0=%h exp state=%0d pc=0000 instr0=20000000", current_state, pc, instr0, STATE_EXEC); end
      step();
      checks++; if (current_state !== 4'(STATE_FETCH0) || mem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_continue got state=%0d addr=%h exp state=%0d addr=0000", current_state, mem_addr, STATE_FETCH0); end
      step();
      step();
      pc_we = 1'b1; pc_din = 16'h0080;
      step();
      pc_we = 1'b0;
      step();
      step();
      checks++; if (current_state !== 4'(STATE_HLT) || pc !== 16'h0081) begin failures++; $display("FAIL wrap_end got state=%0d pc=%h exp state=%0d pc=0081", current_state, pc, STATE_HLT); end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      rom[0] = 32'h02000000;
      rom[1] = 32'hAAAA5555;
      rom[2] = 32'h03000000;
      rom[3] = 32'h12345678;
      run = 1'b1;
      step();
      run = 1'b0;
      n = 0;
      while (!(current_state === 4'(STATE_FETCH1_L) && pc === 16'h0003) && n < 20) begin step(); n++; end
      checks++; if (current_state !== 4'(STATE_FETCH1_L) || instr1 !== 32'hAAAA5555) begin failures++; $display("FAIL rm_reach got state=%0d instr1=%h exp state=%0d instr1=aaaa5555", current_state, instr1, STATE_FETCH1_L); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (current_state !== 4'(STATE_HLT) || halted !== 1'b1) begin failures++; $display("FAIL rm_state got=%0d exp=%0d", current_state, STATE_HLT); end
      checks++; if (instr1 !== 32'h0 || instr0 !== 32'h0) begin failures++; $display("FAIL rm_instr got=%h/%h exp=0/0", instr0, instr1); end
      checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL rm_pc got=%h exp=0000", pc); end
      n = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (current_state !== 4'(STATE_HLT)) n++;
      end
      checks++; if (n != 0) begin failures++; $display("FAIL rm_no_exec got=%0d non-idle cycles exp=0", n); end
   endtask

   task automatic test_random();
      logic [PW-1:0] mpc;
      logic [7:0]    op;
      logic [31:0]   e0, e1;
      logic [3:0]    est;
      int            k, lat, sel;
      bit            jump;
      for (int i = 0; i < 256; i++) begin
         sel = $urandom_range(0, 7);
         if (sel == 0)      op = 8'hFF;
         else if (sel == 1) op = 8'h02;
         else if (sel == 2) op = 8'h03;
         else               op = 8'($urandom_range(4, 254));
         rom[i] = {op, 24'($urandom)};
      end
      do_reset();
      mpc = '0;
      run = 1'b1;
      for (int n = 0; n < 60; n++) begin
         op = rom[mpc][31:24];
         e0 = rom[mpc];
         e1 = 32'h0;
         if (op == 8'hFF) begin
            lat = 3; est = 4'(STATE_HLT); mpc = mpc + 16'd1;
         end else if (op == 8'h02 || op == 8'h03) begin
            lat = 5; est = 4'(STATE_EXEC); e1 = rom[16'(mpc + 16'd1)]; mpc = mpc + 16'd2;
         end else begin
            lat = 3; est = 4'(STATE_EXEC); mpc = mpc + 16'd1;
         end
         k = 0;
         do begin
            step();
            k++;
            if (current_state !== 4'(STATE_EXEC) && current_state !== 4'(STATE_HLT)) begin
               run = 1'($urandom); pc_we = 1'($urandom); pc_din = 16'($urandom);
            end
         end while (current_state !== 4'(STATE_EXEC) && current_state !== 4'(STATE_HLT) && k < 12);
         checks++; if (current_state !== est || k != lat) begin failures++; $display("FAIL rnd_seq[%0d] got state=%0d cycles=%0d exp state=%0d cycles=%0d", n, current_state, k, est, lat); end
         checks++; if (pc !== mpc || mem_addr !== mpc) begin failures++; $display("FAIL rnd_pc[%0d] got pc=%h addr=%h exp=%h", n, pc, mem_addr, mpc); end
         if (current_state !== est) begin
            run = 1'b0; pc_we = 1'b0;
            return;
         end
         if (est == 4'(STATE_EXEC)) begin
            checks++; if (instr0 !== e0 || instr1 !== e1 || halted !== 1'b0) begin failures++; $display("FAIL rnd_instr[%0d] got=%h/%h/%b exp=%h/%h/0", n, instr0, instr1, halted, e0, e1); end
            run = 1'($urandom);
            jump = 1'($urandom);
            pc_we = jump;
            pc_din = 16'($urandom_range(0, 63));
            if (jump) mpc = pc_din;
         end else begin
            checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rnd_halted[%0d] got=%b exp=1", n, halted); end
            run = 1'b1;
            pc_we = 1'($urandom);
            pc_din = 16'($urandom);
         end
      end
      run = 1'b0; pc_we = 1'b0;
   endtask

   initial begin
      reset = 1'b0; run = 1'b0; pc_we = 1'b0; pc_din = '0;
      for (int i = 0; i < 65536; i++) rom[i] = 32'h0;
      test_reset();
      test_one_word();
      test_two_word();
      test_jump();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing controller for the OSECPU core. It sits directly upstream of the execute datapath. It walks the program counter through a synchronous instruction ROM, assembles one- or two-word instructions into `instr0`/`instr1`, and drives `current_state` so the datapath acts for exactly one cycle per instruction. It also accepts a PC reload from the execute stage for jumps and halts on `OP_END`.

## Interface
Parameters:
- `PC_WIDTH`, default 16: program counter and ROM address width.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `run`, input, 1: start pulse; honoured only in `STATE_HLT`.
- `mem_addr`, output, `PC_WIDTH`: ROM address; combinationally equal to `pc`.
- `mem_data`, input, 32: ROM read data; valid the cycle after `mem_addr` is sampled (1-cycle latency).
- `pc_we`, input, 1: jump request from the execute stage; honoured only in `STATE_EXEC`.
- `pc_din`, input, `PC_WIDTH`: jump target.
- `current_state`, output, 4: registered FSM state (`STATE_*` encoding).
- `instr0`, output, 32: first instruction word.
- `instr1`, output, 32: second word (immediate) for two-word ops, else 0.
- `pc`, output, `PC_WIDTH`: program counter.
- `halted`, output, 1: high while in `STATE_HLT`.

## Operation
- States:
  - `STATE_HLT`: idle. `run` moves to `STATE_FETCH0`.
  - `STATE_FETCH0`: ROM samples `pc`.
  - `STATE_FETCH0_L`:
    - `instr0 <= mem_data` and `pc <= pc+1`.
    - If `mem_data[31:24]==OP_END`, go to `STATE_HLT` and do not execute.
    - Else if opcode is two-word (`OP_LIMM32`=8'h02, `OP_PLIMM`=8'h03), go to `STATE_FETCH1`.
    - Else `instr1 <= 0` and go to `STATE_EXEC`.
  - `STATE_FETCH1`: ROM samples `pc`.
  - `STATE_FETCH1_L`: `instr1 <= mem_data`, `pc <= pc+1`, go to `STATE_EXEC`.
  - `STATE_EXEC`:
    - Exactly one cycle; the datapath acts on `instr0`/`instr1` during it.
    - If `pc_we`, then `pc <= pc_din`.
    - Go to `STATE_FETCH0`.
- `instr0`/`instr1` hold stable from their latch until the next `STATE_FETCH0_L`. They are unchanged in `STATE_EXEC` and `STATE_HLT`.
- Unknown opcodes are single-word and still pass through `STATE_EXEC`; the datapath treats them as no-ops.
- PC arithmetic is modulo 2^`PC_WIDTH`: `pc`=all-ones increments to 0.
- `pc_we` outside `STATE_EXEC` is ignored. `run` outside `STATE_HLT` is ignored.
- The `OP_END` word's address is consumed, so `pc` ends at END address + 1.
- In `STATE_HLT`, a new `run` resumes from the current `pc`.

## Timing
- Reset values: `current_state`=`STATE_HLT`, `pc`=`RESET_PC`, `instr0`=0, `instr1`=0, `halted`=1. `mem_addr` follows `pc`.
- `reset` wins over `run` and `pc_we` in the same cycle. Reset mid-fetch or mid-exec aborts immediately; no partial instruction survives.
- The first `STATE_FETCH0` is the cycle after `run` is sampled.
- Latency:
  - One-word instruction: 3 cycles (FETCH0, FETCH0_L, EXEC).
  - Two-word instruction: 5 cycles.
- `STATE_EXEC` is the only state in which the datapath may assert register writes.
- A jump taken in EXEC: the next FETCH0 presents `pc_din` on `mem_addr`.

## Structure
- All `STATE_*` 4-bit encodings and `OP_*` opcodes live in the shared `def.v` package; `STATE_EXEC` keeps its existing value.
- Add `STATE_HLT`, `STATE_FETCH0`, `STATE_FETCH0_L`, `STATE_FETCH1`, `STATE_FETCH1_L`, `OP_LIMM32`, `OP_PLIMM`, `OP_END` to `def.v`.
- One natural sub-module: `instr_len_decode`. It is combinational: opcode in, `is_two_word` and `is_end` out. Later multi-word opcodes are added there only.

## Test plan
- Reset: hold `reset` 2 cycles with `run`=1 → `current_state`=`STATE_HLT`, `pc`=0, `instr0`=0, `halted`=1.
- One-word instruction: ROM[0]=32'h02... replaced by 32'h10_04_10_80 (OR), ROM[1]=32'hFF000000; pulse `run` →
  - `STATE_EXEC` on cycle 3 with `instr0`=32'h10041080 and `instr1`=0;
  - then FETCH0/FETCH0_L, `STATE_HLT`, `pc`=2.
- Two-word instruction: ROM[0]=32'h02040000, ROM[1]=32'hDEADBEEF →
  - EXEC on cycle 5 with `instr0`=32'h02040000 and `instr1`=32'hDEADBEEF;
  - `pc`=2 in EXEC.
- Jump: assert `pc_we`=1, `pc_din`=16'h0040 in EXEC → the next cycle's `mem_addr`=16'h0040. `pc_we` asserted in FETCH0 → no effect.
- Wrap: `RESET_PC`=16'hFFFF, one-word op at FFFF → `pc`=0 after FETCH0_L; the fetch continues from address 0.
- Reset mid-operation: assert `reset` in `STATE_FETCH1_L` → next cycle `STATE_HLT`, `instr1`=0, `pc`=`RESET_PC`, and no EXEC cycle occurs.
